// File: rtl/types_pkg.sv
// types_pkg: shared RV32I pipeline types for the execute stage and its ALU.
package types_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } aluop_e;
  typedef enum logic [1:0] {SRCA_REG = 2'd0, SRCA_PC = 2'd1, SRCA_ZERO = 2'd2} srca_sel_e;
  typedef enum logic [1:0] {FWD_NONE = 2'd0, FWD_WB = 2'd1, FWD_MEM = 2'd2} fwd_sel_e;
  typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2} result_src_e;
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_f3_e;
endpackage

// File: rtl/ex_stage_alu.sv
// alu: combinational RV32I ALU; undefined operation encodings behave as ADD.
module alu import types_pkg::*; (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  aluop_e          op_i,
  output logic [XLEN-1:0] y_o
);
  logic [4:0] sh;
  assign sh = b_i[4:0];
  always_comb begin
    case (op_i)
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << sh;
      ALU_SLT:  y_o = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU: y_o = XLEN'(a_i < b_i);
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> sh;
      ALU_SRA:  y_o = $signed(a_i) >>> sh;
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = a_i + b_i;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: ID/EX register, forwarding, ALU, branch/jump resolution and EX/MEM register.
module ex_stage import types_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_pc_plus4,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  aluop_e            id_alu_control,
  input  srca_sel_e         id_srca_sel,
  input  logic              id_alu_src,
  input  logic [2:0]        id_funct3,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  result_src_e       id_result_src,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              id_jalr,
  input  fwd_sel_e          forward_a,
  input  fwd_sel_e          forward_b,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_is_load,
  output logic              ex_pc_src,
  output logic [XLEN-1:0]   ex_pc_target,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_alu_result,
  output logic [XLEN-1:0]   mem_write_data,
  output logic [4:0]        mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_write,
  output result_src_e       mem_result_src,
  output logic [XLEN-1:0]   mem_pc_plus4
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, pc_plus4, rd1, rd2, imm;
    logic [4:0]      rs1, rs2, rd;
    aluop_e          alu_control;
    srca_sel_e       srca_sel;
    logic            alu_src;
    branch_f3_e      funct3;
    logic            reg_write, mem_write;
    result_src_e     result_src;
    logic            branch, jump, jalr;
  } id_ex_t;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_result, write_data;
    logic [4:0]      rd;
    logic            reg_write, mem_write;
    result_src_e     result_src;
    logic [XLEN-1:0] pc_plus4;
  } ex_mem_t;
  id_ex_t          id_in, id_ex_d, id_ex_q;
  ex_mem_t         ex_mem_d, ex_mem_q;
  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_y, jalr_sum;
  logic            eq, lt, ltu, cond;
  assign id_in = '{valid: id_valid, pc: id_pc, pc_plus4: id_pc_plus4, rd1: id_rd1, rd2: id_rd2,
                   imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, alu_control: id_alu_control,
                   srca_sel: id_srca_sel, alu_src: id_alu_src, funct3: branch_f3_e'(id_funct3),
                   reg_write: id_reg_write, mem_write: id_mem_write, result_src: id_result_src,
                   branch: id_branch, jump: id_jump, jalr: id_jalr};
  // flush outranks stall; only the fields that could cause side effects are cleared
  always_comb begin
    id_ex_d = stall_e ? id_ex_q : id_in;
    if (flush_e) begin
      id_ex_d           = id_in;
      id_ex_d.valid     = 1'b0;
      id_ex_d.reg_write = 1'b0;
      id_ex_d.mem_write = 1'b0;
      id_ex_d.branch    = 1'b0;
      id_ex_d.jump      = 1'b0;
      id_ex_d.jalr      = 1'b0;
      id_ex_d.rd        = '0;
    end
  end
  assign fwd_a = forward_a == FWD_MEM ? mem_fwd_data : forward_a == FWD_WB ? wb_fwd_data : id_ex_q.rd1;
  assign fwd_b = forward_b == FWD_MEM ? mem_fwd_data : forward_b == FWD_WB ? wb_fwd_data : id_ex_q.rd2;
  assign src_a = id_ex_q.srca_sel == SRCA_PC ? id_ex_q.pc : id_ex_q.srca_sel == SRCA_ZERO ? '0 : fwd_a;
  assign src_b = id_ex_q.alu_src ? id_ex_q.imm : fwd_b;
  alu u_alu (.a_i(src_a), .b_i(src_b), .op_i(id_ex_q.alu_control), .y_o(alu_y));
  assign eq   = fwd_a == fwd_b;
  assign lt   = $signed(fwd_a) < $signed(fwd_b);
  assign ltu  = fwd_a < fwd_b;
  assign cond = id_ex_q.funct3 == BR_BEQ  ? eq  :
                id_ex_q.funct3 == BR_BNE  ? !eq :
                id_ex_q.funct3 == BR_BLT  ? lt  :
                id_ex_q.funct3 == BR_BGE  ? !lt :
                id_ex_q.funct3 == BR_BLTU ? ltu :
                id_ex_q.funct3 == BR_BGEU ? !ltu : 1'b0;
  assign jalr_sum     = fwd_a + id_ex_q.imm;
  assign ex_pc_src    = id_ex_q.valid & (id_ex_q.jump | (id_ex_q.branch & cond));
  assign ex_pc_target = id_ex_q.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : id_ex_q.pc + id_ex_q.imm;
  assign ex_rs1       = id_ex_q.rs1;
  assign ex_rs2       = id_ex_q.rs2;
  assign ex_rd        = id_ex_q.rd;
  assign ex_is_load   = id_ex_q.valid & (id_ex_q.result_src == RES_MEM);
  assign ex_mem_d = '{valid: id_ex_q.valid, alu_result: alu_y, write_data: fwd_b, rd: id_ex_q.rd,
                      reg_write: id_ex_q.reg_write, mem_write: id_ex_q.mem_write,
                      result_src: id_ex_q.result_src, pc_plus4: id_ex_q.pc_plus4};
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q           <= '0;
      id_ex_q.pc        <= RESET_PC;
      id_ex_q.pc_plus4  <= RESET_PC;
      ex_mem_q          <= '0;
      ex_mem_q.pc_plus4 <= RESET_PC;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
    end
  end
  assign mem_valid      = ex_mem_q.valid;
  assign mem_alu_result = ex_mem_q.alu_result;
  assign mem_write_data = ex_mem_q.write_data;
  assign mem_rd         = ex_mem_q.rd;
  assign mem_reg_write  = ex_mem_q.reg_write;
  assign mem_mem_write  = ex_mem_q.mem_write;
  assign mem_result_src = ex_mem_q.result_src;
  assign mem_pc_plus4   = ex_mem_q.pc_plus4;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed execute-stage bench with an EX/MEM scoreboard queue.
module tb_ex_stage;
  import types_pkg::*;
  localparam logic [31:0] RPC = 32'h0000_1000;
  logic        clk = 1'b0, rst = 1'b0, stall_e = 1'b0, flush_e = 1'b0;
  logic        id_valid, id_alu_src, id_reg_write, id_mem_write, id_branch, id_jump, id_jalr;
  logic [31:0] id_pc, id_pc_plus4, id_rd1, id_rd2, id_imm, mem_fwd_data, wb_fwd_data;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  aluop_e      id_alu_control;
  srca_sel_e   id_srca_sel;
  result_src_e id_result_src, mem_result_src;
  fwd_sel_e    forward_a = FWD_NONE, forward_b = FWD_NONE;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, mem_rd;
  logic        ex_is_load, ex_pc_src, mem_valid, mem_reg_write, mem_mem_write;
  logic [31:0] ex_pc_target, mem_alu_result, mem_write_data, mem_pc_plus4;
  typedef struct {
    bit          full;
    logic        valid, rw, mw;
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    result_src_e rs;
  } exp_t;
  exp_t q[$];
  int passed = 0, total = 0;

  ex_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .id_valid(id_valid),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_srca_sel(id_srca_sel), .id_alu_src(id_alu_src), .id_funct3(id_funct3),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_result_src(id_result_src),
    .id_branch(id_branch), .id_jump(id_jump), .id_jalr(id_jalr), .forward_a(forward_a),
    .forward_b(forward_b), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_pc_src(ex_pc_src), .ex_pc_target(ex_pc_target), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src), .mem_pc_plus4(mem_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %h want %h", tag, o, e);
  endtask

  function automatic exp_t ex(input logic [31:0] alu, wd, input logic [4:0] rd,
                              input logic rw, mw, input result_src_e rs, input logic [31:0] pc4);
    ex = '{full: 1'b1, valid: 1'b1, rw: rw, mw: mw, alu: alu, wd: wd, pc4: pc4, rd: rd, rs: rs};
  endfunction

  function automatic exp_t bub();
    bub = '{full: 1'b0, valid: 1'b0, rw: 1'b0, mw: 1'b0, alu: '0, wd: '0, pc4: '0, rd: '0, rs: RES_ALU};
  endfunction

  task automatic cmp_mem(input exp_t e);
    chk("mem_valid", 32'(mem_valid), 32'(e.valid));
    chk("mem_reg_write", 32'(mem_reg_write), 32'(e.rw));
    chk("mem_mem_write", 32'(mem_mem_write), 32'(e.mw));
    if (e.full) begin
      chk("mem_alu_result", mem_alu_result, e.alu);
      chk("mem_write_data", mem_write_data, e.wd);
      chk("mem_rd", 32'(mem_rd), 32'(e.rd));
      chk("mem_result_src", 32'(mem_result_src), 32'(e.rs));
      chk("mem_pc_plus4", mem_pc_plus4, e.pc4);
    end
  endtask

  task automatic tick(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() > 1) cmp_mem(q.pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_reg_write", 32'(mem_reg_write), 32'd0);
    chk("rst_mem_mem_write", 32'(mem_mem_write), 32'd0);
    chk("rst_mem_result_src", 32'(mem_result_src), 32'(RES_ALU));
    chk("rst_mem_pc_plus4", mem_pc_plus4, RPC);
    chk("rst_ex_pc_src", 32'(ex_pc_src), 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_ex_is_load", 32'(ex_is_load), 32'd0);
    q.delete();
    q.push_back(bub());
  endtask

  task automatic clr();
    id_valid = 1'b1; id_pc = 32'h40; id_pc_plus4 = 32'h44; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = '0; id_alu_control = ALU_ADD; id_srca_sel = SRCA_REG;
    id_alu_src = 1'b0; id_funct3 = 3'b010; id_reg_write = 1'b0; id_mem_write = 1'b0;
    id_result_src = RES_ALU; id_branch = 1'b0; id_jump = 1'b0; id_jalr = 1'b0;
  endtask

  initial begin
    clr();
    mem_fwd_data = '0;
    wb_fwd_data = '0;
    do_reset();
    // ADD 5 + 7
    clr(); id_rd1 = 5; id_rd2 = 7; id_rd = 5'd3; id_reg_write = 1'b1;
    tick(ex(32'd12, 32'd7, 5'd3, 1'b1, 1'b0, RES_ALU, 32'h44));
    chk("add_ex_rd", 32'(ex_rd), 32'd3);
    chk("add_ex_rs1", 32'(ex_rs1), 32'd1);
    chk("add_ex_rs2", 32'(ex_rs2), 32'd2);
    chk("add_ex_pc_src", 32'(ex_pc_src), 32'd0);
    // SRA by immediate 4
    clr(); id_rd1 = 32'h8000_0000; id_imm = 4; id_alu_src = 1'b1; id_alu_control = ALU_SRA;
    id_rd = 5'd4; id_reg_write = 1'b1;
    tick(ex(32'hF800_0000, 32'd0, 5'd4, 1'b1, 1'b0, RES_ALU, 32'h44));
    // SLTU / SLT with 1 vs all-ones
    clr(); id_rd1 = 1; id_rd2 = 32'hFFFF_FFFF; id_alu_control = ALU_SLTU; id_rd = 5'd5; id_reg_write = 1'b1;
    tick(ex(32'd1, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0, RES_ALU, 32'h44));
    clr(); id_rd1 = 1; id_rd2 = 32'hFFFF_FFFF; id_alu_control = ALU_SLT; id_rd = 5'd5; id_reg_write = 1'b1;
    tick(ex(32'd0, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0, RES_ALU, 32'h44));
    // forward A from MEM
    clr(); id_rd1 = 32'h99; id_imm = 1; id_alu_src = 1'b1; id_rd = 5'd6; id_reg_write = 1'b1;
    tick(ex(32'h11, 32'd0, 5'd6, 1'b1, 1'b0, RES_ALU, 32'h44));
    forward_a = FWD_MEM; mem_fwd_data = 32'h10;
    // store with B forwarded from WB
    clr(); id_rd1 = 32'h200; id_rd2 = 32'hAAAA; id_imm = 8; id_alu_src = 1'b1; id_mem_write = 1'b1;
    tick(ex(32'h208, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, RES_ALU, 32'h44));
    forward_a = FWD_NONE; forward_b = FWD_WB; wb_fwd_data = 32'hDEAD_BEEF;
    // BLT -1 < 0, backwards target
    clr(); id_pc = 32'h100; id_pc_plus4 = 32'h104; id_imm = 32'hFFFF_FFF8; id_rd1 = 32'hFFFF_FFFF;
    id_rd2 = 0; id_funct3 = 3'b100; id_branch = 1'b1; id_alu_control = ALU_SUB;
    tick(ex(32'hFFFF_FFFF, 32'd0, 5'd0, 1'b0, 1'b0, RES_ALU, 32'h104));
    forward_b = FWD_NONE;
    #1;
    chk("blt_pc_src", 32'(ex_pc_src), 32'd1);
    chk("blt_target", ex_pc_target, 32'h0F8);
    chk("blt_is_load", 32'(ex_is_load), 32'd0);
    // BGEU 1 >= 0xFFFFFFFF is false
    clr(); id_rd1 = 1; id_rd2 = 32'hFFFF_FFFF; id_funct3 = 3'b111; id_branch = 1'b1;
    tick(ex(32'd0, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, RES_ALU, 32'h44));
    chk("bgeu_pc_src", 32'(ex_pc_src), 32'd0);
    // same BLT loaded under flush becomes a bubble
    clr(); id_pc = 32'h100; id_imm = 32'hFFFF_FFF8; id_rd1 = 32'hFFFF_FFFF; id_funct3 = 3'b100;
    id_branch = 1'b1; id_rd = 5'd9; id_reg_write = 1'b1; flush_e = 1'b1;
    tick(bub());
    flush_e = 1'b0;
    chk("flush_pc_src", 32'(ex_pc_src), 32'd0);
    chk("flush_ex_rd", 32'(ex_rd), 32'd0);
    // JALR clears bit 0 of the target
    clr(); id_pc = 32'h300; id_pc_plus4 = 32'h304; id_rd1 = 32'h2003; id_imm = 2; id_alu_src = 1'b1;
    id_jump = 1'b1; id_jalr = 1'b1; id_rd = 5'd1; id_reg_write = 1'b1; id_result_src = RES_PC4;
    tick(ex(32'h2005, 32'd0, 5'd1, 1'b1, 1'b0, RES_PC4, 32'h304));
    chk("jalr_pc_src", 32'(ex_pc_src), 32'd1);
    chk("jalr_target", ex_pc_target, 32'h2004);
    // load with an undefined ALU encoding, which must add
    clr(); id_rd1 = 32'h1000; id_imm = 4; id_alu_src = 1'b1; id_alu_control = aluop_e'(4'hF);
    id_result_src = RES_MEM; id_rd = 5'd6; id_reg_write = 1'b1;
    tick(ex(32'h1004, 32'd0, 5'd6, 1'b1, 1'b0, RES_MEM, 32'h44));
    chk("lw_is_load", 32'(ex_is_load), 32'd1);
    // ADD held for three stalled cycles while the decode inputs change
    clr(); id_rd1 = 20; id_rd2 = 22; id_rd = 5'd7; id_reg_write = 1'b1;
    tick(ex(32'd42, 32'd22, 5'd7, 1'b1, 1'b0, RES_ALU, 32'h44));
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clr(); id_rd1 = 32'd1000 + i; id_rd = 5'd9; id_rs1 = 5'd11; id_reg_write = 1'b1;
      tick(ex(32'd42, 32'd22, 5'd7, 1'b1, 1'b0, RES_ALU, 32'h44));
      chk("stall_ex_rd", 32'(ex_rd), 32'd7);
      chk("stall_ex_rs1", 32'(ex_rs1), 32'd1);
    end
    flush_e = 1'b1;
    tick(bub());
    stall_e = 1'b0; flush_e = 1'b0;
    chk("stallflush_ex_rd", 32'(ex_rd), 32'd0);
    // reset while instructions are in flight
    clr(); id_rd1 = 1; id_rd2 = 1; id_rd = 5'd8; id_reg_write = 1'b1;
    tick(ex(32'd2, 32'd1, 5'd8, 1'b1, 1'b0, RES_ALU, 32'h44));
    clr(); id_jump = 1'b1; id_rd = 5'd10; id_reg_write = 1'b1;
    do_reset();
    clr(); id_rd1 = 3; id_rd2 = 4; id_rd = 5'd2; id_reg_write = 1'b1;
    tick(ex(32'd7, 32'd4, 5'd2, 1'b1, 1'b0, RES_ALU, 32'h44));
    clr(); id_valid = 1'b0;
    tick(bub());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
